// File: rtl/ntsc_pattern_seq.sv
// Multi-mode RGB332 test-pattern sequencer: bars, palette, grey ramp, scrolling checker, solid.
// 1-clk registered latency from x/y/active_video; no backpressure (free-running pixel stream).
module ntsc_pattern_seq #(
    parameter int          X_W             = 10,
    parameter int          Y_W             = 9,
    parameter int          BAR_SHIFT       = 6,
    parameter int          CHK_SHIFT       = 4,
    parameter int          FRAMES_PER_MODE = 120,
    parameter int          SCROLL_STEP     = 2,
    parameter logic [7:0]  FG_COLOR        = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic             active_video,
    input  logic             frame_tick,
    input  logic             auto_en,
    input  logic [2:0]       mode_sel,
    input  logic [7:0]       solid_rgb,
    output logic [7:0]       rgb,
    output logic [2:0]       mode,
    output logic             mode_strobe
);

    localparam int CNT_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MODE - 1);

    logic [CNT_W-1:0] cnt;
    logic [X_W-1:0]   offset;

    logic [X_W-1:0]   bar_full;
    logic [2:0]       bar_idx;
    logic [X_W-1:0]   scroll_x;
    logic             chk_bit;
    logic [2:0]       grey;
    logic [7:0]       pattern;
    logic [2:0]       next_mode;
    logic [CNT_W-1:0] next_cnt;
    logic             unused_bits;

    assign unused_bits = ^{x, y, scroll_x, bar_full};

    always_comb begin
        bar_full = x >> BAR_SHIFT;
        bar_idx  = bar_full[2:0];
        scroll_x = x + offset;
        chk_bit  = scroll_x[CHK_SHIFT] ^ y[CHK_SHIFT];
        grey     = x[8:6];
        pattern  = 8'h00;
        case (mode)
            3'd0: begin
                case (bar_idx)
                    3'd0:    pattern = 8'hFF;
                    3'd1:    pattern = 8'hFC;
                    3'd2:    pattern = 8'h1F;
                    3'd3:    pattern = 8'h1C;
                    3'd4:    pattern = 8'hE3;
                    3'd5:    pattern = 8'hE0;
                    3'd6:    pattern = 8'h03;
                    default: pattern = 8'h00;
                endcase
            end
            3'd1:    pattern = {y[6:4], x[8:4]};
            3'd2:    pattern = {grey, grey, grey[2:1]};
            3'd3:    pattern = chk_bit ? FG_COLOR : 8'h00;
            3'd4:    pattern = solid_rgb;
            default: pattern = 8'h00;
        endcase
    end

    // Mode/counter value to load on a frame_tick; codes above 4 clamp to bars.
    always_comb begin
        next_mode = mode;
        next_cnt  = cnt;
        if (!auto_en) begin
            next_mode = (mode_sel > 3'd4) ? 3'd0 : mode_sel;
            next_cnt  = '0;
        end else if (cnt == CNT_LAST) begin
            next_cnt  = '0;
            next_mode = (mode == 3'd4) ? 3'd0 : mode + 3'd1;
        end else begin
            next_cnt  = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb         <= 8'h00;
            mode        <= 3'd0;
            mode_strobe <= 1'b0;
            cnt         <= '0;
            offset      <= '0;
        end else begin
            rgb         <= active_video ? pattern : 8'h00;
            mode_strobe <= frame_tick && (next_mode != mode);
            if (frame_tick) begin
                mode   <= next_mode;
                cnt    <= next_cnt;
                offset <= offset + X_W'(SCROLL_STEP);
            end
        end
    end

endmodule

// File: tb/tb_ntsc_pattern_seq.sv
// Directed bench for ntsc_pattern_seq with a pixel scoreboard; FRAMES_PER_MODE=3 to keep auto-cycle short.
module tb_ntsc_pattern_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       active_video = 1'b1;
    logic       frame_tick = 1'b0;
    logic       auto_en = 1'b0;
    logic [2:0] mode_sel = 3'd0;
    logic [7:0] solid_rgb = 8'h00;
    logic [7:0] rgb;
    logic [2:0] mode;
    logic       mode_strobe;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    ntsc_pattern_seq #(
        .X_W(10), .Y_W(9), .BAR_SHIFT(6), .CHK_SHIFT(4),
        .FRAMES_PER_MODE(3), .SCROLL_STEP(2), .FG_COLOR(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active_video(active_video),
        .frame_tick(frame_tick), .auto_en(auto_en), .mode_sel(mode_sel),
        .solid_rgb(solid_rgb), .rgb(rgb), .mode(mode), .mode_strobe(mode_strobe)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one pixel, queue its expected colour, compare once it emerges a clock later.
    task automatic px(input logic [9:0] xi, input logic [8:0] yi, input logic av,
                      input logic [7:0] e, input string tag);
        x = xi; y = yi; active_video = av;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk); #1;
        chk(tag_q.pop_front(), rgb, exp_q.pop_front());
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bars [8];
        int strobes;
        bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

        // Reset held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", rgb, 8'h00);
        chk("rst_mode", {5'd0, mode}, 8'd0);
        chk("rst_strobe", {7'd0, mode_strobe}, 8'd0);
        rst = 1'b1;
        px(10'd0, 9'd0, 1'b1, 8'hFF, "release_rgb");
        chk("release_mode", {5'd0, mode}, 8'd0);

        // Colour bars then blanking
        for (int i = 0; i < 8; i++) px(10'(i * 64), 9'd0, 1'b1, bars[i], $sformatf("bar%0d", i));
        px(10'd0, 9'd0, 1'b0, 8'h00, "blank");

        // Manual switching happens only on frame_tick
        mode_sel = 3'd3;
        px(10'd0, 9'd0, 1'b1, 8'hFF, "no_tick_rgb");
        chk("no_tick_mode", {5'd0, mode}, 8'd0);
        chk("no_tick_strobe", {7'd0, mode_strobe}, 8'd0);
        tick();
        chk("man3_mode", {5'd0, mode}, 8'd3);
        chk("man3_strobe", {7'd0, mode_strobe}, 8'd1);
        @(posedge clk); #1;
        chk("man3_strobe_end", {7'd0, mode_strobe}, 8'd0);
        mode_sel = 3'd6;
        tick();
        chk("clamp_mode", {5'd0, mode}, 8'd0);
        chk("clamp_strobe", {7'd0, mode_strobe}, 8'd1);
        tick();
        chk("same_strobe", {7'd0, mode_strobe}, 8'd0);

        // Auto-cycle, 3 frames per mode
        auto_en = 1'b1;
        strobes = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (mode_strobe) strobes++;
            chk($sformatf("auto_mode_t%0d", k), {5'd0, mode}, 8'((k / 3) % 5));
        end
        chk("auto_strobes", 8'(strobes), 8'd5);
        auto_en = 1'b0;

        // Scrolling checker: loading mode 3 itself advances offset to 2
        do_reset();
        mode_sel = 3'd3;
        tick();
        px(10'd12, 9'd0, 1'b1, 8'h00, "scroll_off2");
        px(10'd12, 9'd16, 1'b1, 8'hFF, "scroll_off2_y16");
        tick();
        px(10'd12, 9'd0, 1'b1, 8'hFF, "scroll_off4");
        frame_tick = 1'b1;
        repeat (511) @(posedge clk);
        #1;
        frame_tick = 1'b0;
        px(10'd12, 9'd0, 1'b1, 8'h00, "scroll_wrap");
        chk("scroll_mode_kept", {5'd0, mode}, 8'd3);

        // Grey ramp, palette grid, solid
        mode_sel = 3'd2;
        tick();
        px(10'd448, 9'd0, 1'b1, 8'hFF, "grey448");
        px(10'd64, 9'd0, 1'b1, 8'h24, "grey64");
        mode_sel = 3'd1;
        tick();
        px(10'h1F0, 9'h050, 1'b1, 8'hBF, "palette");
        mode_sel = 3'd4;
        tick();
        solid_rgb = 8'h5A;
        px(10'd100, 9'd7, 1'b1, 8'h5A, "solid5A");
        solid_rgb = 8'hA5;
        px(10'd100, 9'd7, 1'b1, 8'hA5, "solidA5");
        mode_sel = 3'd5;
        tick();
        chk("clamp5_mode", {5'd0, mode}, 8'd0);

        // Mid-frame reset takes effect on the same edge
        mode_sel = 3'd4;
        tick();
        x = 10'd0; active_video = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset_rgb", rgb, 8'h00);
        chk("midreset_mode", {5'd0, mode}, 8'd0);
        rst = 1'b1;
        px(10'd64, 9'd0, 1'b1, 8'hFC, "after_midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
